sd_cmd_sequencer: RTL and testbench

//  Upstream controller for the spi byte engine (enviar_dato/recibir_dato/din/dout). Turns one host

---
 rtl/sd_cmd_sequencer_pkg.sv | 28 ++
 rtl/sd_cmd_sequencer_byte_slot.sv | 57 +++++
 rtl/sd_cmd_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_sd_cmd_sequencer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_cmd_sequencer_pkg.sv
// Shared definitions for the SD-card SPI command sequencer: FSM states, frame tokens, R1 helpers.
package sd_cmd_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_CMD,
    ST_POLL,
    ST_RESP,
    ST_POST,
    ST_INIT
  } state_t;

  localparam logic [1:0] START_TOKEN = 2'b01;
  localparam logic [7:0] FILL_BYTE   = 8'hFF;
  localparam int         CMD_BYTES   = 6;
  localparam logic [2:0] RESP_MAX    = 3'd4;

  // An R1 response is recognised by its cleared start bit.
  function automatic logic r1_valid(input logic [7:0] b);
    return ~b[7];
  endfunction

  function automatic logic [2:0] clamp_resp(input logic [2:0] n);
    return (n > RESP_MAX) ? RESP_MAX : n;
  endfunction

endpackage

// File: rtl/sd_cmd_sequencer_byte_slot.sv
// One SPI byte slot: request high for BYTE_CLKS cycles, then GAP_CLKS idle cycles.
module spi_byte_slot
  import sd_cmd_sequencer_pkg::*;
#(
  parameter int BYTE_CLKS = 18,
  parameter int GAP_CLKS  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  logic       rx,
  input  logic [7:0] txbyte,
  output logic       enviar,
  output logic       recibir,
  output logic [7:0] din,
  output logic       sample_stb,
  output logic       slot_done
);

  localparam int SLOT_CLKS = BYTE_CLKS + GAP_CLKS;
  localparam int CW        = $clog2(SLOT_CLKS);
  localparam logic [CW-1:0] LAST    = CW'(SLOT_CLKS - 1);
  localparam logic [CW-1:0] REQ_END = CW'(BYTE_CLKS);

  logic          active;
  logic          rx_q;
  logic [CW-1:0] cnt;
  logic          req;

  // A go in the last cycle of a slot chains the next slot with no bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      active <= 1'b0;
      rx_q   <= 1'b0;
      cnt    <= '0;
      din    <= FILL_BYTE;
    end else if (go) begin
      active <= 1'b1;
      rx_q   <= rx;
      cnt    <= '0;
      din    <= rx ? FILL_BYTE : txbyte;
    end else if (active && (cnt == LAST)) begin
      active <= 1'b0;
      cnt    <= '0;
      din    <= FILL_BYTE;
    end else if (active) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign req        = active && (cnt < REQ_END);
  assign enviar     = req && !rx_q;
  assign recibir    = req && rx_q;
  assign sample_stb = active && (cnt == REQ_END);
  assign slot_done  = active && (cnt == LAST);

endmodule

// File: rtl/sd_cmd_sequencer.sv
// SD-card SPI command sequencer: builds command frames, polls R1, collects response bytes, runs preamble.
module sd_cmd_sequencer
  import sd_cmd_sequencer_pkg::*;
#(
  parameter int BYTE_CLKS  = 18,
  parameter int GAP_CLKS   = 2,
  parameter int NCR_MAX    = 8,
  parameter int INIT_BYTES = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_start,
  input  logic        cmd_init,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  input  logic [6:0]  cmd_crc,
  input  logic [2:0]  resp_bytes,
  input  logic        keep_cs,
  output logic        busy,
  output logic        done,
  output logic [7:0]  r1,
  output logic [31:0] resp_data,
  output logic        timeout,
  output logic        spi_enviar_dato,
  output logic        spi_recibir_dato,
  output logic [7:0]  spi_din,
  input  logic [7:0]  spi_dout,
  output logic        sd_cs_n
);

  localparam logic [7:0] INIT_LAST = 8'(INIT_BYTES - 1);
  localparam logic [7:0] CMD_LAST  = 8'(CMD_BYTES - 1);
  localparam logic [7:0] NCR_LAST  = 8'(NCR_MAX - 1);

  state_t      state, state_d;
  logic [7:0]  byte_cnt, byte_cnt_d;
  logic        go, rx_d, finish;
  logic [7:0]  txbyte;
  logic        accept_init, accept_start, got_r1, poll_timeout, resp_shift;
  logic        sample_stb, slot_done;

  logic [5:0]  idx_q;
  logic [31:0] arg_q;
  logic [6:0]  crc_q;
  logic [2:0]  nresp_q;
  logic        keep_q;
  logic [7:0]  rx_byte;

  function automatic logic [7:0] cmd_byte(input logic [7:0] n, input logic [5:0] idx,
                                          input logic [31:0] arg, input logic [6:0] crc);
    case (n)
      8'd0:    return {START_TOKEN, idx};
      8'd1:    return arg[31:24];
      8'd2:    return arg[23:16];
      8'd3:    return arg[15:8];
      8'd4:    return arg[7:0];
      default: return {crc, 1'b1};
    endcase
  endfunction

  // Next state is decided at each slot end so the following slot's byte is ready for go.
  always_comb begin
    state_d      = state;
    byte_cnt_d   = byte_cnt;
    go           = 1'b0;
    accept_init  = 1'b0;
    accept_start = 1'b0;
    got_r1       = 1'b0;
    poll_timeout = 1'b0;
    resp_shift   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cmd_init) begin
          accept_init = 1'b1;
          state_d     = ST_INIT;
          byte_cnt_d  = '0;
          go          = 1'b1;
        end else if (cmd_start) begin
          accept_start = 1'b1;
          state_d      = ST_PRE;
          byte_cnt_d   = '0;
          go           = 1'b1;
        end
      end
      default: begin
        if (slot_done) begin
          go         = 1'b1;
          byte_cnt_d = byte_cnt + 8'd1;
          case (state)
            ST_INIT: begin
              if (byte_cnt == INIT_LAST) begin
                state_d = ST_IDLE;
                go      = 1'b0;
              end
            end
            ST_PRE: begin
              state_d    = ST_CMD;
              byte_cnt_d = '0;
            end
            ST_CMD: begin
              if (byte_cnt == CMD_LAST) begin
                state_d    = ST_POLL;
                byte_cnt_d = '0;
              end
            end
            ST_POLL: begin
              if (r1_valid(rx_byte)) begin
                got_r1     = 1'b1;
                byte_cnt_d = '0;
                state_d    = (nresp_q == 3'd0) ? ST_POST : ST_RESP;
              end else if (byte_cnt == NCR_LAST) begin
                poll_timeout = 1'b1;
                state_d      = ST_POST;
              end
            end
            ST_RESP: begin
              resp_shift = 1'b1;
              if (byte_cnt + 8'd1 == {5'd0, nresp_q}) state_d = ST_POST;
            end
            default: begin
              state_d = ST_IDLE;
              go      = 1'b0;
            end
          endcase
        end
      end
    endcase
    finish = (state != ST_IDLE) && slot_done && (state_d == ST_IDLE);
    rx_d   = (state_d == ST_POLL) || (state_d == ST_RESP);
    txbyte = (state_d == ST_CMD) ? cmd_byte(byte_cnt_d, idx_q, arg_q, crc_q) : FILL_BYTE;
  end

  // busy is held through the done cycle so a back-to-back pulse never sees it drop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      byte_cnt  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      r1        <= FILL_BYTE;
      resp_data <= '0;
      timeout   <= 1'b0;
      sd_cs_n   <= 1'b1;
    end else begin
      state    <= state_d;
      byte_cnt <= byte_cnt_d;
      done     <= finish;
      busy     <= (state_d != ST_IDLE) || finish;
      if (accept_init) begin
        sd_cs_n <= 1'b1;
        timeout <= 1'b0;
      end
      if (accept_start) begin
        sd_cs_n   <= 1'b0;
        timeout   <= 1'b0;
        resp_data <= '0;
      end
      if (got_r1) r1 <= rx_byte;
      if (poll_timeout) begin
        r1      <= FILL_BYTE;
        timeout <= 1'b1;
      end
      if (resp_shift) resp_data <= {resp_data[23:0], rx_byte};
      if (finish && (state == ST_POST) && !keep_q) sd_cs_n <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept_start) begin
      idx_q   <= cmd_index;
      arg_q   <= cmd_arg;
      crc_q   <= cmd_crc;
      nresp_q <= clamp_resp(resp_bytes);
      keep_q  <= keep_cs;
    end
    if (sample_stb) rx_byte <= spi_dout;
  end

  spi_byte_slot #(
    .BYTE_CLKS(BYTE_CLKS),
    .GAP_CLKS (GAP_CLKS)
  ) u_slot (
    .clk       (clk),
    .rst       (rst),
    .go        (go),
    .rx        (rx_d),
    .txbyte    (txbyte),
    .enviar    (spi_enviar_dato),
    .recibir   (spi_recibir_dato),
    .din       (spi_din),
    .sample_stb(sample_stb),
    .slot_done (slot_done)
  );

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// Bench for sd_cmd_sequencer: SD-card response model, transmit-byte scoreboard, frame vector table.
module tb_sd_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_start = 1'b0;
  logic        cmd_init = 1'b0;
  logic [5:0]  cmd_index = '0;
  logic [31:0] cmd_arg = '0;
  logic [6:0]  cmd_crc = '0;
  logic [2:0]  resp_bytes = '0;
  logic        keep_cs = 1'b0;
  logic        busy, done, timeout;
  logic [7:0]  r1;
  logic [31:0] resp_data;
  logic        spi_enviar_dato, spi_recibir_dato;
  logic [7:0]  spi_din;
  logic [7:0]  spi_dout = 8'hFF;
  logic        sd_cs_n;

  sd_cmd_sequencer dut (
    .clk             (clk),
    .rst             (rst),
    .cmd_start       (cmd_start),
    .cmd_init        (cmd_init),
    .cmd_index       (cmd_index),
    .cmd_arg         (cmd_arg),
    .cmd_crc         (cmd_crc),
    .resp_bytes      (resp_bytes),
    .keep_cs         (keep_cs),
    .busy            (busy),
    .done            (done),
    .r1              (r1),
    .resp_data       (resp_data),
    .timeout         (timeout),
    .spi_enviar_dato (spi_enviar_dato),
    .spi_recibir_dato(spi_recibir_dato),
    .spi_din         (spi_din),
    .spi_dout        (spi_dout),
    .sd_cs_n         (sd_cs_n)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_tx[$];
  logic [7:0] model_rsp[$];
  int rx_slots = 0;
  int cs_low_cycles = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: times every request pulse, checks transmit bytes against the scoreboard and
  // plays the card by returning the next queued response byte for each receive.
  logic       prev_env = 1'b0, prev_rec = 1'b0;
  int         env_len = 0, rec_len = 0;
  logic [7:0] tx_seen = 8'h00, rx_din_seen = 8'h00;
  logic       din_unstable = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      prev_env = 1'b0;
      prev_rec = 1'b0;
      env_len  = 0;
      rec_len  = 0;
    end else begin
      if (!sd_cs_n) cs_low_cycles++;
      if (spi_enviar_dato || spi_recibir_dato)
        check("req_exclusive", 32'(spi_enviar_dato & spi_recibir_dato), 32'd0);
      if (spi_enviar_dato) begin
        if (!prev_env) begin
          env_len      = 0;
          tx_seen      = spi_din;
          din_unstable = 1'b0;
        end
        env_len++;
        if (spi_din !== tx_seen) din_unstable = 1'b1;
      end else if (prev_env) begin
        check("tx_len", 32'(env_len), 32'd18);
        check("tx_din_stable", 32'(din_unstable), 32'd0);
        if (exp_tx.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL tx_unexpected: got byte %h, expected no transmit", tx_seen);
        end else begin
          check("tx_byte", 32'(tx_seen), 32'(exp_tx.pop_front()));
        end
      end
      if (spi_recibir_dato) begin
        if (!prev_rec) begin
          rec_len     = 0;
          rx_din_seen = spi_din;
          spi_dout    = (model_rsp.size() != 0) ? model_rsp.pop_front() : 8'hFF;
        end
        rec_len++;
      end else if (prev_rec) begin
        rx_slots++;
        check("rx_len", 32'(rec_len), 32'd18);
        check("rx_din_ff", 32'(rx_din_seen), 32'hFF);
      end
      prev_env = spi_enviar_dato;
      prev_rec = spi_recibir_dato;
    end
  end

  task automatic wait_done(input int max_cyc, output int cyc);
    cyc = 0;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (done || cyc >= max_cyc) break;
    end
    check("done_seen", 32'(done), 32'd1);
  endtask

  typedef struct packed {
    logic [5:0]  idx;
    logic [31:0] arg;
    logic [6:0]  crc;
    logic [2:0]  nresp;
    logic        keep;
    logic [3:0]  n_rsp;
    logic [79:0] rsp;
    logic [7:0]  exp_r1;
    logic [31:0] exp_data;
    logic        exp_to;
    logic        exp_cs;
    logic [7:0]  exp_rx;
  } vec_t;

  vec_t vecs[6];

  task automatic push_frame(input vec_t v);
    exp_tx.push_back(8'hFF);
    exp_tx.push_back({2'b01, v.idx});
    exp_tx.push_back(v.arg[31:24]);
    exp_tx.push_back(v.arg[23:16]);
    exp_tx.push_back(v.arg[15:8]);
    exp_tx.push_back(v.arg[7:0]);
    exp_tx.push_back({v.crc, 1'b1});
    exp_tx.push_back(8'hFF);
  endtask

  task automatic run_frame(input vec_t v, input string tag, input logic poke_busy);
    int cyc;
    model_rsp.delete();
    for (int i = 0; i < int'(v.n_rsp); i++) model_rsp.push_back(v.rsp[79-8*i -: 8]);
    push_frame(v);
    cmd_index  = v.idx;
    cmd_arg    = v.arg;
    cmd_crc    = v.crc;
    resp_bytes = v.nresp;
    keep_cs    = v.keep;
    rx_slots   = 0;
    @(negedge clk) cmd_start = 1'b1;
    @(negedge clk) cmd_start = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    if (poke_busy) begin
      repeat (30) @(negedge clk);
      cmd_index  = 6'h3F;
      cmd_arg    = 32'hDEADBEEF;
      cmd_crc    = 7'h11;
      resp_bytes = 3'd3;
      keep_cs    = ~v.keep;
      cmd_start  = 1'b1;
      @(negedge clk) cmd_start = 1'b0;
    end
    wait_done(2000, cyc);
    check({tag, "_busy_at_done"}, 32'(busy), 32'd1);
    check({tag, "_r1"}, 32'(r1), 32'(v.exp_r1));
    check({tag, "_resp_data"}, resp_data, v.exp_data);
    check({tag, "_timeout"}, 32'(timeout), 32'(v.exp_to));
    check({tag, "_cs_n"}, 32'(sd_cs_n), 32'(v.exp_cs));
    check({tag, "_rx_slots"}, 32'(rx_slots), 32'(v.exp_rx));
    check({tag, "_tx_left"}, 32'(exp_tx.size()), 32'd0);
  endtask

  task automatic run_init(input logic with_start, input string tag);
    int cyc;
    for (int i = 0; i < 10; i++) exp_tx.push_back(8'hFF);
    cs_low_cycles = 0;
    rx_slots      = 0;
    @(negedge clk) begin
      cmd_init  = 1'b1;
      cmd_start = with_start;
    end
    @(negedge clk) begin
      cmd_init  = 1'b0;
      cmd_start = 1'b0;
    end
    check({tag, "_busy"}, 32'(busy), 32'd1);
    wait_done(400, cyc);
    check({tag, "_done_latency"}, 32'(cyc), 32'd200);
    check({tag, "_cs_low_cycles"}, 32'(cs_low_cycles), 32'd0);
    check({tag, "_tx_left"}, 32'(exp_tx.size()), 32'd0);
    check({tag, "_rx_slots"}, 32'(rx_slots), 32'd0);
    repeat (30) @(negedge clk);
    check({tag, "_idle_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{idx: 6'd0, arg: 32'h0, crc: 7'h4A, nresp: 3'd0, keep: 1'b0,
                n_rsp: 4'd3, rsp: {24'hFFFF01, 56'd0},
                exp_r1: 8'h01, exp_data: 32'h0, exp_to: 1'b0, exp_cs: 1'b1, exp_rx: 8'd3};
    vecs[1] = '{idx: 6'd8, arg: 32'h1AA, crc: 7'h43, nresp: 3'd4, keep: 1'b0,
                n_rsp: 4'd5, rsp: {40'h01000001AA, 40'd0},
                exp_r1: 8'h01, exp_data: 32'h000001AA, exp_to: 1'b0, exp_cs: 1'b1, exp_rx: 8'd5};
    vecs[2] = '{idx: 6'h11, arg: 32'h12345678, crc: 7'h2A, nresp: 3'd2, keep: 1'b0,
                n_rsp: 4'd0, rsp: 80'd0,
                exp_r1: 8'hFF, exp_data: 32'h0, exp_to: 1'b1, exp_cs: 1'b1, exp_rx: 8'd8};
    vecs[3] = '{idx: 6'h3A, arg: 32'h0, crc: 7'h7E, nresp: 3'd7, keep: 1'b0,
                n_rsp: 4'd6, rsp: {48'h00C0FF800011, 32'd0},
                exp_r1: 8'h00, exp_data: 32'hC0FF8000, exp_to: 1'b0, exp_cs: 1'b1, exp_rx: 8'd5};
    vecs[4] = '{idx: 6'h10, arg: 32'h00000200, crc: 7'h0A, nresp: 3'd2, keep: 1'b0,
                n_rsp: 4'd10, rsp: 80'hFFFFFFFFFFFFFF05ABCD,
                exp_r1: 8'h05, exp_data: 32'h0000ABCD, exp_to: 1'b0, exp_cs: 1'b1, exp_rx: 8'd10};
    vecs[5] = '{idx: 6'h37, arg: 32'h0, crc: 7'h32, nresp: 3'd0, keep: 1'b1,
                n_rsp: 4'd1, rsp: {8'h01, 72'd0},
                exp_r1: 8'h01, exp_data: 32'h0, exp_to: 1'b0, exp_cs: 1'b0, exp_rx: 8'd1};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_r1", 32'(r1), 32'hFF);
    check("rst_resp_data", resp_data, 32'h0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_enviar", 32'(spi_enviar_dato), 32'd0);
    check("rst_recibir", 32'(spi_recibir_dato), 32'd0);
    check("rst_din", 32'(spi_din), 32'hFF);
    check("rst_cs_n", 32'(sd_cs_n), 32'd1);

    run_init(1'b0, "init");

    for (int i = 0; i < 6; i++) run_frame(vecs[i], $sformatf("vec%0d", i), 1'b0);

    // cs stays low across a frame that follows a keep_cs frame; a mid-frame start is ignored
    run_frame(vecs[0], "busy_start", 1'b1);
    repeat (25) @(negedge clk);
    check("busy_start_no_restart", 32'(busy), 32'd0);
    check("busy_start_tx_left", 32'(exp_tx.size()), 32'd0);

    run_init(1'b1, "init_wins");

    // reset in the middle of the command bytes
    model_rsp.delete();
    push_frame(vecs[1]);
    cmd_index  = vecs[1].idx;
    cmd_arg    = vecs[1].arg;
    cmd_crc    = vecs[1].crc;
    resp_bytes = vecs[1].nresp;
    keep_cs    = 1'b1;
    @(negedge clk) cmd_start = 1'b1;
    @(negedge clk) cmd_start = 1'b0;
    repeat (50) @(negedge clk);
    check("pre_rst_cs_n", 32'(sd_cs_n), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("abort_cs_n", 32'(sd_cs_n), 32'd1);
    check("abort_enviar", 32'(spi_enviar_dato), 32'd0);
    check("abort_recibir", 32'(spi_recibir_dato), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_din", 32'(spi_din), 32'hFF);
    @(negedge clk) rst = 1'b0;
    exp_tx.delete();
    repeat (40) @(negedge clk);
    check("abort_stays_idle", 32'(busy), 32'd0);
    check("abort_no_tx", 32'(exp_tx.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
